// File: rtl/sigdiv_iter.sv
// Iterative radix-2 restoring divider for normalized significands.
// Produces one quotient bit per clock; emits a truncated quotient, a sticky bit and an invalid-divisor flag.
module sigdiv_iter #(
  parameter int W  = 58,
  parameter int QW = W + 2,
  parameter int CW = $clog2(QW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] q,
  output logic          sticky,
  output logic          inv
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [W:0]    r;
  logic [W-1:0]  d;
  // The accumulator's top bit is only ever needed in qnext, so it is never stored.
  logic [QW-2:0] qacc;
  logic [CW-1:0] cnt;

  logic          qbit;
  logic [W:0]    r_sub;
  logic [QW-1:0] qnext;

  always_comb begin
    qbit  = (r >= {1'b0, d});
    r_sub = qbit ? (r - {1'b0, d}) : r;
    qnext = {qacc, qbit};
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      inv    <= 1'b0;
      sticky <= 1'b0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      qacc   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b[W-1]) begin
              r     <= {1'b0, a};
              d     <= b;
              qacc  <= '0;
              cnt   <= CW'(QW - 1);
              inv   <= 1'b0;
              state <= RUN;
            end else begin
              q      <= '1;
              sticky <= 1'b0;
              inv    <= 1'b1;
              done   <= 1'b1;
            end
          end
        end
        RUN: begin
          // r_sub < d < 2^W, so the shifted remainder always fits in W+1 bits.
          r    <= {r_sub[W-1:0], 1'b0};
          qacc <= qnext[QW-2:0];
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            q      <= qnext;
            sticky <= (r_sub != '0);
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigdiv_iter.sv
// Scoreboard bench for sigdiv_iter: expected results are queued at start and checked on each done pulse.
module tb_sigdiv_iter;
  localparam int W  = 58;
  localparam int QW = W + 2;
  localparam logic [W-1:0]  P57  = 58'd1 << 57;
  localparam logic [W-1:0]  P56  = 58'd1 << 56;
  localparam logic [QW-1:0] ONES = {QW{1'b1}};

  typedef struct packed {
    logic [QW-1:0] q;
    logic          s;
    logic          i;
  } exp_t;

  logic          clk, rst, start;
  logic [W-1:0]  opa, opb;
  logic          busy, done, sticky, inv;
  logic [QW-1:0] q;

  exp_t sb[$];
  int   checks, fails, ndone;

  sigdiv_iter #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(opa), .b(opb),
    .busy(busy), .done(done), .q(q), .sticky(sticky), .inv(inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] na, input logic [W-1:0] nb);
    exp_t e;
    logic [127:0] num, den;
    if (!nb[W-1]) begin
      e.q = ONES; e.s = 1'b0; e.i = 1'b1;
    end else begin
      num = 128'(na) << (QW - 1);
      den = 128'(nb);
      e.q = QW'(num / den);
      e.s = ((num % den) != 0);
      e.i = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      ndone++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("sticky", sticky, e.s);
        chk("inv", inv, e.i);
      end
    end
  end

  // Counts edges after the accepting edge until done is seen (0 = done right after acceptance).
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic go(input logic [W-1:0] na, input logic [W-1:0] nb, input exp_t e,
                    input int exp_lat, input string tag);
    int k;
    @(negedge clk);
    opa = na; opb = nb; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, (exp_lat != 0));
    wait_done(k);
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    exp_t e1, e2;
    int   k, n0;
    checks = 0; fails = 0; ndone = 0;
    rst = 1'b1; start = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_inv", inv, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;

    // 1: unity quotient, exactly one done pulse
    n0 = ndone;
    go(P57, P57, '{q: 60'h800_0000_0000_0000, s: 1'b0, i: 1'b0}, QW, "t1");
    repeat (5) @(posedge clk);
    #1 chk("t1_one_done", ndone - n0, 1);

    // 2: 1/1.5 and 1.5/1
    go(P57, P57 | P56, '{q: 60'h555_5555_5555_5555, s: 1'b1, i: 1'b0}, QW, "t2a");
    go(P57 | P56, P57, '{q: 60'hC00_0000_0000_0000, s: 1'b0, i: 1'b0}, QW, "t2b");

    // 3: largest dividend over smallest divisor; zero dividend
    go({W{1'b1}}, P57, '{q: 60'hFFF_FFFF_FFFF_FFFC, s: 1'b0, i: 1'b0}, QW, "t3a");
    go('0, P57, '{q: 60'h0, s: 1'b0, i: 1'b0}, QW, "t3b");

    // 4: unnormalized divisors
    go(P57, '0, '{q: ONES, s: 1'b0, i: 1'b1}, 0, "t4a");
    go(P57, P56, '{q: ONES, s: 1'b0, i: 1'b1}, 0, "t4b");

    // 5: start while busy is dropped; start in the done cycle is taken
    e1 = '{q: 60'h555_5555_5555_5555, s: 1'b1, i: 1'b0};
    @(negedge clk);
    opa = P57; opb = P57 | P56; start = 1'b1;
    sb.push_back(e1);
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    opa = {W{1'b1}}; opb = P57; start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("t5_busy_ign", busy, 1);
    wait_done(k);
    chk("t5_done_seen", done, 1);
    e2 = model(P57 | P56, P57);
    opa = P57 | P56; opb = P57; start = 1'b1;
    sb.push_back(e2);
    @(posedge clk); #1 start = 1'b0;
    chk("t5_busy_b2b", busy, 1);
    chk("t5_q_hold", q, e1.q);
    wait_done(k);
    chk("t5_lat_b2b", k, QW);

    // 6: reset mid-iteration abandons the operation
    @(negedge clk);
    opa = P57; opb = P57; start = 1'b1;
    sb.push_back(model(P57, P57));
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_q", q, 0);
    chk("t6_sticky", sticky, 0);
    chk("t6_inv", inv, 0);
    chk("t6_done", done, 0);
    chk("t6_busy", busy, 0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    n0 = ndone;
    repeat (80) @(posedge clk);
    #1 chk("t6_no_done", ndone - n0, 0);
    go(P57 | 58'd12345, P57 | 58'd777, model(P57 | 58'd12345, P57 | 58'd777), QW, "t6_after");

    // random normalized pairs against the arithmetic contract
    for (int i = 0; i < 800; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'({$urandom, $urandom});
      rb = W'({$urandom, $urandom}) | P57;
      if (i % 16 == 0) ra = '0;
      go(ra, rb, model(ra, rb), QW, "rnd");
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
